result_accumulator: RTL and testbench

Downstream stage that consumes the 4-bit arithmetic results produced by the add/subtract datapath block and accumulates fixed-size bursts of them into a signed running total. Input and output use valid/ready handshakes. Each completed burst is presented as one accumulated word. An overflow flag marks bursts whose total left the accumulator range.

---
 rtl/result_acc_pkg.sv | 20 ++
 rtl/acc_sat_adder.sv | 40 ++++
 rtl/result_accumulator.sv | 117 +++++++++++
 tb/tb_result_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_acc_pkg.sv
// Shared types and constants for the result_accumulator burst stage.
// Every rtl/ file imports this package.
package result_acc_pkg;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 6;
  localparam int BURST  = 4;
  localparam int CNT_W  = $clog2(BURST + 1);

  // Two's-complement limits of the accumulator, used when clamping.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_sat_adder.sv
// One accumulate step: acc +/- zero-extended operand, combinational.
// ACC_SAT_EN selects clamping with overflow detect; otherwise the result wraps.
module acc_sat_adder
  import result_acc_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              sub,
  output logic [ACC_W-1:0]  next_acc,
  output logic              step_ovf
);

`ifdef ACC_SAT_EN
  // One guard bit holds every true result: |operand| is below 2^(ACC_W-1).
  logic [ACC_W:0] wide_acc;
  logic [ACC_W:0] wide_opd;
  logic [ACC_W:0] wide_sum;

  always_comb begin
    wide_acc = {acc[ACC_W-1], acc};
    wide_opd = {{(ACC_W+1-DATA_W){1'b0}}, operand};
    wide_sum = sub ? (wide_acc - wide_opd) : (wide_acc + wide_opd);
    step_ovf = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    if (!step_ovf) begin
      next_acc = wide_sum[ACC_W-1:0];
    end else if (wide_sum[ACC_W]) begin
      next_acc = ACC_MIN;
    end else begin
      next_acc = ACC_MAX;
    end
  end
`else
  logic [ACC_W-1:0] opd;

  assign opd      = {{(ACC_W-DATA_W){1'b0}}, operand};
  assign next_acc = sub ? (acc - opd) : (acc + opd);
  assign step_ovf = 1'b0;
`endif

endmodule

// File: rtl/result_accumulator.sv
// Accumulates BURST signed steps into one word behind valid/ready handshakes.
// Build with ACC_SAT_EN to clamp the total and report a sticky overflow flag.
module result_accumulator
  import result_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  state_e           state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q,  out_data_d;
  logic             out_ovf_q,   out_ovf_d;

  logic             accept;
  logic [ACC_W-1:0] step_acc;
  logic             step_ovf;

  assign accept = in_valid && in_ready_q;

  acc_sat_adder u_adder (
    .acc      (acc_q),
    .operand  (in_data),
    .sub      (in_sub),
    .next_acc (step_acc),
    .step_ovf (step_ovf)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_d = step_acc;
          ovf_d = ovf_q | step_ovf;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BURST - 1)) begin
            out_data_d  = step_acc;
            out_ovf_d   = ovf_q | step_ovf;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // out_data/out_ovf stay untouched here until the handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: all state, including the output word, is reset so a burst cut
  // short by rst leaves nothing behind; non-blocking keeps updates ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator: vector table, corner sequences
// and randomized bursts against an integer reference model.
module tb_result_accumulator;
  import result_acc_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sub;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  int checks   = 0;
  int failures = 0;

  result_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [4*BURST-1:0] d;
    logic [BURST-1:0]   s;
    int                 gap;
    int                 hold;
    int                 exp;
    logic               ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic s);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    while (!in_ready && n < 16) begin
      step();
      n++;
    end
    check("send_ready", in_ready, 1);
    step();
  endtask

  // Reference: true signed sum per step, then clamp or wrap to the ACC_W range.
  function automatic int model_burst(input logic [4*BURST-1:0] d,
                                     input logic [BURST-1:0] s,
                                     output logic ovf);
    int acc;
    int hi;
    int lo;
    acc = 0;
    ovf = 1'b0;
    hi  = (1 << (ACC_W - 1)) - 1;
    lo  = -(1 << (ACC_W - 1));
    for (int i = 0; i < BURST; i++) begin
      acc = s[i] ? acc - int'(d[DATA_W*i +: DATA_W]) : acc + int'(d[DATA_W*i +: DATA_W]);
`ifdef ACC_SAT_EN
      if (acc > hi) begin
        acc = hi;
        ovf = 1'b1;
      end else if (acc < lo) begin
        acc = lo;
        ovf = 1'b1;
      end
`else
      while (acc > hi) acc -= (1 << ACC_W);
      while (acc < lo) acc += (1 << ACC_W);
`endif
    end
    return acc;
  endfunction

  task automatic do_burst(input string name, input logic [4*BURST-1:0] d,
                          input logic [BURST-1:0] s, input int gap, input int hold,
                          input int exp, input logic eovf);
    logic [ACC_W-1:0] held;
    out_ready = (hold == 0);
    for (int i = 0; i < BURST; i++) begin
      in_valid = 1'b0;
      repeat (gap) step();
      send(d[DATA_W*i +: DATA_W], s[i]);
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_in_ready_low"}, in_ready, 0);
    check({name, "_data"}, $signed(out_data), exp);
    check({name, "_ovf"}, out_ovf, eovf);
    held     = out_data;
    in_valid = (hold > 0);
    in_data  = 4'hF;
    in_sub   = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, "_hold_data"}, out_data, held);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, "_done_valid"}, out_valid, 0);
    check({name, "_done_in_ready"}, in_ready, 1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_out_ovf"}, out_ovf, 0);
  endtask

  task automatic release_reset();
    step();
    rst = 1'b0;
    check("rel_in_ready_low", in_ready, 0);
    step();
    check("rel_in_ready_high", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*BURST-1:0] rd;
    logic [BURST-1:0]   rs;
    logic               rovf;
    int                 rexp;

    vecs[0] = '{"adds",  {4'd1, 4'd2, 4'd5, 4'd3}, 4'b0000, 0, 0, 11, 1'b0};
    vecs[1] = '{"mixed", {4'd1, 4'd7, 4'd4, 4'd9}, 4'b0110, 0, 5, -1, 1'b0};
`ifdef ACC_SAT_EN
    vecs[2] = '{"pos_ovf", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b0000, 0, 0, 31, 1'b1};
    vecs[3] = '{"neg_ovf", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b1111, 1, 0, -32, 1'b1};
    vecs[4] = '{"recover", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b1000, 0, 2, 16, 1'b1};
`else
    vecs[2] = '{"pos_ovf", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b0000, 0, 0, -4, 1'b0};
    vecs[3] = '{"neg_ovf", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b1111, 1, 0, 4, 1'b0};
    vecs[4] = '{"recover", {4'd15, 4'd15, 4'd15, 4'd15}, 4'b1000, 0, 2, 30, 1'b0};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #12;
    check_reset_values("por");
    release_reset();

    for (int i = 0; i < 5; i++) begin
      do_burst(vecs[i].name, vecs[i].d, vecs[i].s, vecs[i].gap, vecs[i].hold,
               vecs[i].exp, vecs[i].ovf);
    end

    // Reset after two of four samples: partial total must be discarded.
    out_ready = 1'b1;
    send(4'd7, 1'b0);
    send(4'd6, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_burst");
    release_reset();
    do_burst("after_rst", {4'd1, 4'd1, 4'd1, 4'd1}, 4'b0000, 0, 0, 4, 1'b0);

    // Reset while a word waits in HOLD: the pending result is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < BURST; i++) send(4'd5, 1'b0);
    in_valid = 1'b0;
    check("hold_pending_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_hold");
    release_reset();

    for (int n = 0; n < 30; n++) begin
      rd   = (4*BURST)'($urandom);
      rs   = BURST'($urandom);
      rexp = model_burst(rd, rs, rovf);
      do_burst("rand", rd, rs, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               rexp, rovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
